// File: rtl/arith_req_arbiter.sv
// Round-robin arbiter sharing one registered arithmetic unit between NREQ requesters.
// Optional macro ARITH_ARB_DIVZERO_CHECK_EN answers divide-by-zero directly without using the unit.
module arith_req_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_A,
    input  logic [NREQ*WIDTH-1:0] req_B,
    input  logic [2*NREQ-1:0]     req_fun,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_result,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      alu_A,
    output logic [WIDTH-1:0]      alu_B,
    output logic [1:0]            alu_fun,
    output logic                  alu_enable,
    input  logic [2*WIDTH-1:0]    alu_out,
    input  logic                  alu_carry,
    input  logic                  alu_flag,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [IDW:0]    NREQ_L   = (IDW+1)'(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [1:0]           fun_q, fun_d;
    logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic                 rsp_carry_q, rsp_carry_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0]     a_arr   [NREQ];
    logic [WIDTH-1:0]     b_arr   [NREQ];
    logic [1:0]           fun_arr [NREQ];
    logic [IDW-1:0]       cand_idx [NREQ];

    logic                 grant_found;
    logic [IDW-1:0]       grant_idx;
    logic                 grant_en;
    logic [IDW:0]         ptr_inc;
    logic [IDW-1:0]       ptr_next;

    // cand_idx[k] is the requester examined k-th, starting from ptr and wrapping
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            logic [IDW:0] sum;
            assign a_arr[gi]   = req_A[gi*WIDTH +: WIDTH];
            assign b_arr[gi]   = req_B[gi*WIDTH +: WIDTH];
            assign fun_arr[gi] = req_fun[gi*2 +: 2];
            assign sum          = {1'b0, ptr_q} + (IDW+1)'(gi);
            assign cand_idx[gi] = (sum >= NREQ_L) ? IDW'(sum - NREQ_L) : sum[IDW-1:0];
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
        grant_en  = (state_q == S_IDLE) && grant_found && !RST;
        req_ready = grant_en ? (ONE_HOT0 << grant_idx) : '0;
        ptr_inc   = {1'b0, grant_idx} + (IDW+1)'(1);
        ptr_next  = (ptr_inc == NREQ_L) ? '0 : ptr_inc[IDW-1:0];
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        fun_d        = fun_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    ptr_d   = ptr_next;
                    id_d    = grant_idx;
                    a_d     = a_arr[grant_idx];
                    b_d     = b_arr[grant_idx];
                    fun_d   = fun_arr[grant_idx];
                    state_d = S_ISSUE;
`ifdef ARITH_ARB_DIVZERO_CHECK_EN
                    if (fun_arr[grant_idx] == 2'b11 && b_arr[grant_idx] == '0) begin
                        state_d      = S_RESP;
                        rsp_result_d = '0;
                        rsp_carry_d  = 1'b0;
                        rsp_err_d    = 1'b1;
                    end
`endif
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_d      = S_RESP;
                rsp_result_d = alu_out;
                rsp_carry_d  = alu_carry;
                rsp_err_d    = ~alu_flag;
            end
            default: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            fun_q        <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            fun_q        <= fun_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = (state_q == S_RESP);
    assign alu_enable = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_fun    = fun_q;

endmodule

// File: tb/tb_arith_req_arbiter.sv
// Directed bench for arith_req_arbiter with a small behavioural arithmetic unit attached.
module tb_arith_req_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_A;
    logic [63:0] req_B;
    logic [7:0]  req_fun;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_err;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [1:0]  alu_fun;
    logic        alu_enable;
    logic [31:0] alu_out = '0;
    logic        alu_carry = 1'b0;
    logic        alu_flag;
    logic        busy;

    logic        flag_q = 1'b1;
    logic        force_flag_low = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    arith_req_arbiter #(.WIDTH(16), .NREQ(4)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_fun(req_fun),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .alu_A(alu_A), .alu_B(alu_B), .alu_fun(alu_fun), .alu_enable(alu_enable),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_flag(alu_flag),
        .busy(busy)
    );

    // Unit model: {flag, carry, result}; carry marks results outside the signed operand range
    function automatic logic [33:0] unit_calc(input logic [15:0] a, input logic [15:0] b,
                                              input logic [1:0] f);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r  = 0;
        logic   fl = 1'b1;
        case (f)
            2'b00: r = sa + sb;
            2'b01: r = sa - sb;
            2'b10: r = sa * sb;
            default: begin
                if (sb == 0) fl = 1'b0;
                else         r  = sa / sb;
            end
        endcase
        return {fl, (r > 32767 || r < -32768), r[31:0]};
    endfunction

    always @(posedge CLK) begin
        if (alu_enable) {flag_q, alu_carry, alu_out} <= unit_calc(alu_A, alu_B, alu_fun);
    end
    assign alu_flag = flag_q & ~force_flag_low;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] f);
        req_A[i*16 +: 16] = a;
        req_B[i*16 +: 16] = b;
        req_fun[i*2 +: 2] = f;
    endtask

    initial begin
        logic [3:0] oh;
        RST = 1'b1; req_valid = '0; req_A = '0; req_B = '0; req_fun = '0; rsp_ready = 1'b1;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_alu_enable", alu_enable, 0);
        chk("rst_req_ready", req_ready, 0);
        RST = 1'b0;
        step();

        // single request from requester 2: 7 + (-3)
        set_req(2, 16'd7, 16'hFFFD, 2'b00);
        req_valid = 4'b0100; #1;
        chk("t1_grant", req_ready, 4'b0100);
        chk("t1_busy_T", busy, 0);
        step(); req_valid = '0; #1;
        chk("t1_enable_T1", alu_enable, 1);
        chk("t1_alu_A", alu_A, 16'd7);
        chk("t1_alu_B", alu_B, 16'hFFFD);
        chk("t1_alu_fun", alu_fun, 2'b00);
        chk("t1_rsp_valid_T1", rsp_valid, 0);
        chk("t1_busy_T1", busy, 1);
        step();
        chk("t1_enable_T2", alu_enable, 0);
        chk("t1_rsp_valid_T2", rsp_valid, 0);
        step();
        chk("t1_rsp_valid_T3", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 2);
        chk("t1_rsp_result", rsp_result, 32'd4);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_carry", rsp_carry, 0);
        step();
        chk("t1_rsp_valid_T4", rsp_valid, 0);
        chk("t1_busy_T4", busy, 0);
        chk("t1_alu_A_hold", alu_A, 16'd7);

        // reset during WAIT drops the in-flight response
        set_req(3, 16'd50, 16'd2, 2'b00);
        req_valid = 4'b1000; #1;
        chk("rw_grant", req_ready, 4'b1000);
        step(); req_valid = '0;
        step();
        RST = 1'b1;
        step();
        chk("rw_busy", busy, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_alu_enable", alu_enable, 0);
        chk("rw_alu_A", alu_A, 0);
        chk("rw_alu_B", alu_B, 0);
        chk("rw_alu_fun", alu_fun, 0);
        chk("rw_rsp_id", rsp_id, 0);
        chk("rw_rsp_result", rsp_result, 0);
        chk("rw_rsp_err", rsp_err, 0);
        chk("rw_rsp_carry", rsp_carry, 0);
        RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rw_no_rsp", rsp_valid, 0);
            chk("rw_idle", busy, 0);
        end

        // all four requesters contend with 300*300
        for (int r = 0; r < 4; r++) set_req(r, 16'd300, 16'd300, 2'b10);
        req_valid = 4'b1111; #1;
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << (g % 4);
            chk("rr_grant", req_ready, oh);
            step();
            if (g == 4) req_valid = '0;
            #1;
            chk("rr_enable", alu_enable, 1);
            chk("rr_no_grant_issue", req_ready, 0);
            step();
            chk("rr_no_grant_wait", req_ready, 0);
            step();
            chk("rr_rsp_valid", rsp_valid, 1);
            chk("rr_rsp_id", rsp_id, g % 4);
            chk("rr_rsp_result", rsp_result, 32'd90000);
            chk("rr_rsp_carry", rsp_carry, 1);
            step();
        end

        // response back-pressure: 100 / 5 from requester 1 held for 10 cycles
        set_req(1, 16'd100, 16'd5, 2'b11);
        req_valid = 4'b0010; #1;
        chk("bp_grant", req_ready, 4'b0010);
        step(); req_valid = '0;
        step(); step();
        rsp_ready = 1'b0;
        set_req(3, 16'hFFFB, 16'd4, 2'b01);
        req_valid = 4'b1000; #1;
        for (int c = 0; c < 10; c++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_id", rsp_id, 1);
            chk("bp_rsp_result", rsp_result, 32'd20);
            chk("bp_no_grant", req_ready, 0);
            step();
        end
        rsp_ready = 1'b1; #1;
        chk("bp_handshake_no_grant", req_ready, 0);
        chk("bp_handshake_valid", rsp_valid, 1);
        step();
        chk("bp_resume_grant", req_ready, 4'b1000);
        chk("bp_resume_rsp_valid", rsp_valid, 0);
        step(); req_valid = '0; #1;
        chk("bp_sub_enable", alu_enable, 1);
        chk("bp_sub_fun", alu_fun, 2'b01);
        step(); step();
        chk("bp_sub_valid", rsp_valid, 1);
        chk("bp_sub_id", rsp_id, 3);
        chk("bp_sub_result", rsp_result, 32'hFFFFFFF7);
        chk("bp_sub_carry", rsp_carry, 0);
        chk("bp_sub_err", rsp_err, 0);
        step();

        // divide by zero from requester 1
        set_req(1, 16'd10, 16'd0, 2'b11);
        req_valid = 4'b0010; #1;
        chk("dz_grant", req_ready, 4'b0010);
        step(); req_valid = '0; #1;
`ifdef ARITH_ARB_DIVZERO_CHECK_EN
        chk("dz_no_enable", alu_enable, 0);
        chk("dz_rsp_valid_T1", rsp_valid, 1);
        chk("dz_rsp_id", rsp_id, 1);
        chk("dz_rsp_err", rsp_err, 1);
        chk("dz_rsp_result", rsp_result, 0);
        chk("dz_rsp_carry", rsp_carry, 0);
        step();
        chk("dz_done", rsp_valid, 0);
`else
        chk("dz_enable_T1", alu_enable, 1);
        chk("dz_alu_B", alu_B, 0);
        chk("dz_rsp_valid_T1", rsp_valid, 0);
        step();
        chk("dz_rsp_valid_T2", rsp_valid, 0);
        chk("dz_enable_T2", alu_enable, 0);
        step();
        chk("dz_rsp_valid_T3", rsp_valid, 1);
        chk("dz_rsp_id", rsp_id, 1);
        chk("dz_rsp_err", rsp_err, 1);
        step();
        chk("dz_done", rsp_valid, 0);
`endif

        // unit flag low while waiting -> error response
        set_req(0, 16'd1, 16'd2, 2'b00);
        req_valid = 4'b0001; #1;
        chk("fl_grant", req_ready, 4'b0001);
        step(); req_valid = '0;
        step();
        force_flag_low = 1'b1;
        step();
        force_flag_low = 1'b0; #1;
        chk("fl_rsp_valid", rsp_valid, 1);
        chk("fl_rsp_id", rsp_id, 0);
        chk("fl_rsp_result", rsp_result, 32'd3);
        chk("fl_rsp_err", rsp_err, 1);
        step();
        chk("fl_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_req_arbiter.md
# arith_req_arbiter

Round-robin scheduler that shares one registered arithmetic unit (add/sub/mul/div, one-cycle registered latency) between NREQ requesters. Each request is accepted with a valid/ready handshake. The block latches the operands, drives the unit for exactly one enable cycle, and captures the registered result. It returns the result to the originating requester, tagged with its ID, through a valid/ready response channel. It sits between the requesting datapath blocks and the arithmetic unit; no other block drives the unit's operand or control inputs.

## Interface
- WIDTH, 16: operand width; results are 2*WIDTH.
- NREQ, 4: number of requesters, 2..8.
- IDW, $clog2(NREQ): requester ID width.

- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot accept pulse to the granted requester.
- req_A  in  NREQ*WIDTH  signed operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_B  in  NREQ*WIDTH  signed operand B; same slicing as req_A.
- req_fun  in  2*NREQ  opcode per requester: 00 add, 01 sub, 10 mul, 11 div.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  IDW  ID of the requester being answered.
- rsp_result  out  2*WIDTH  signed result.
- rsp_carry  out  1  carry/overflow bit from the unit.
- rsp_err  out  1  error (see Operation).
- alu_A, alu_B  out  WIDTH  operands to the unit.
- alu_fun  out  2  opcode to the unit.
- alu_enable  out  1  unit enable.
- alu_out  in  2*WIDTH  registered result from the unit.
- alu_carry  in  1  registered carry from the unit.
- alu_flag  in  1  registered valid flag from the unit.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE → ISSUE when any req_valid is high.
  - ISSUE → WAIT unconditionally.
  - WAIT → RESP unconditionally.
  - RESP → IDLE when rsp_ready is high.
- Grant (IDLE only):
  - Search starts at pointer ptr and wraps modulo NREQ; the first i with req_valid[i]=1 wins.
  - req_ready[i]=1 in that cycle only.
  - Operands, opcode and ID are latched at the same edge.
  - ptr becomes (i+1) mod NREQ.
- req_ready is combinational from state and req_valid. It is all-zero outside IDLE and all-zero when no request is valid.
- ISSUE:
  - alu_enable=1 for exactly one cycle.
  - alu_A, alu_B and alu_fun carry the latched values; they hold those values in every state until the next grant.
- WAIT: the unit output is registered. At the WAIT→RESP edge the block captures rsp_result=alu_out, rsp_carry=alu_carry and rsp_err=~alu_flag.
- RESP:
  - rsp_valid=1.
  - rsp_id, rsp_result, rsp_carry and rsp_err stay stable until the rsp_ready handshake.
- rsp_valid & rsp_ready in the same cycle completes the response. If req_valid is high in that cycle it is not granted; the grant happens in the following IDLE cycle.
- A requester must hold req_valid and its operands stable until its req_ready pulse.
- Result arithmetic is done entirely by the unit; the block performs no sign extension or truncation.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_err=0, alu_A=0, alu_B=0, alu_fun=00, alu_enable=0, busy=0.
- Accept cycle T: rsp_valid rises at T+3 when the divide-by-zero short path is not taken.
- Minimum spacing between grants is 4 cycles with rsp_ready tied high.
- RST asserted in any state: at the next edge the block returns to reset values and any in-flight response is discarded. alu_enable is 0 from that edge onward.
- rsp_ready held low: the block stays in RESP indefinitely with no new grants, and every req_ready stays 0.

## Configuration
- ARITH_ARB_DIVZERO_CHECK_EN defined:
  - A grant with fun=11 and B=0 goes IDLE→RESP directly, with no ISSUE and no alu_enable pulse.
  - rsp_result=0, rsp_carry=0, rsp_err=1.
  - rsp_valid rises at T+1.
  - ptr advances normally.
- ARITH_ARB_DIVZERO_CHECK_EN undefined:
  - Divide-by-zero is issued like any other operation.
  - The response carries whatever the unit produces.
  - rsp_err reflects ~alu_flag only.

## Test plan
- Single request, requester 2: A=7, B=-3, fun=00, rsp_ready=1 → req_ready[2] at T; alu_enable at T+1 only; rsp_valid at T+3 with rsp_id=2, rsp_result=4, rsp_err=0.
- All four requesters valid continuously with mul A=300, B=300 → grants in order 0,1,2,3,0, spaced 4 cycles apart; every rsp_result=90000 and rsp_carry=1.
- rsp_ready held low for 10 cycles during RESP → rsp_id and rsp_result stable throughout; no req_ready pulse; grant resumes in the IDLE cycle after the handshake.
- RST pulsed during WAIT → all outputs at reset values at the next edge; the dropped response is never presented; the next grant starts from requester 0.
- With ARITH_ARB_DIVZERO_CHECK_EN, requester 1 issues A=10, B=0, fun=11 → no alu_enable pulse; rsp_valid at T+1 with rsp_err=1, rsp_result=0. Without the macro → alu_enable pulses at T+1 and rsp_valid rises at T+3.
- alu_flag forced low during WAIT → rsp_err=1 in the response.
